// File: rtl/qenc_pkg.sv
// Shared widths, direction encoding and saturation limits for the quadrature
// speed-measurement blocks.
package qenc_pkg;

  localparam int VEL_W_DEF = 16;
  localparam int PER_W_DEF = 24;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // One decoded edge: up&down together never forms a valid event
  typedef struct packed {
    logic vld;
    logic dir;
  } qedge_t;

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/qenc_window_timer.sv
// Free-running 0..WINDOW_CYCLES-1 window counter; held at 0 while disabled,
// win_end marks the final cycle of each window.
module qenc_window_timer #(
  parameter int WINDOW_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic win_end
);

  localparam int CW = $clog2(WINDOW_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(WINDOW_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              cnt <= '0;
    else if (!en)          cnt <= '0;
    else if (cnt == LAST)  cnt <= '0;
    else                   cnt <= cnt + 1'b1;
  end

  assign win_end = en && (cnt == LAST);

endmodule

// File: rtl/quadrature_velocity_estimator.sv
// M-method windowed edge count plus T-method edge-to-edge period with stall
// detection, fed by single-cycle up/down strobes from the quadrature decoder.
module quadrature_velocity_estimator
  import qenc_pkg::*;
#(
  parameter int WINDOW_CYCLES = 1000,
  parameter int VEL_W         = VEL_W_DEF,
  parameter int PER_W         = PER_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    up,
  input  logic                    down,
  output logic signed [VEL_W-1:0] velocity,
  output logic                    vel_valid,
  output logic                    vel_sat,
  output logic [PER_W-1:0]        period,
  output logic                    period_dir,
  output logic                    period_valid,
  output logic                    stalled
);

  localparam logic signed [VEL_W:0]   VMAX_X = (VEL_W+1)'(sat_max(VEL_W));
  localparam logic signed [VEL_W:0]   VMIN_X = (VEL_W+1)'(sat_min(VEL_W));
  localparam logic signed [VEL_W-1:0] VMAX   = VMAX_X[VEL_W-1:0];
  localparam logic signed [VEL_W-1:0] VMIN   = VMIN_X[VEL_W-1:0];
  localparam logic [PER_W-1:0]        PMAX   = '1;

  qedge_t evt;
  logic   win_end;

  assign evt.vld = up ^ down;
  assign evt.dir = up ? DIR_UP : DIR_DOWN;

  qenc_window_timer #(.WINDOW_CYCLES(WINDOW_CYCLES)) u_win (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .win_end (win_end)
  );

  // ---- windowed accumulator ----
  logic signed [VEL_W-1:0] acc, acc_nxt;
  logic signed [VEL_W:0]   acc_x, step_x, sum;
  logic                    sticky, sat_now;

  assign acc_x = {acc[VEL_W-1], acc};

  always_comb begin
    step_x  = '0;
    if (evt.vld) step_x = (evt.dir == DIR_UP) ? (VEL_W+1)'(1) : '1;
    sum     = acc_x + step_x;
    acc_nxt = sum[VEL_W-1:0];
    sat_now = 1'b0;
    if (sum > VMAX_X) begin
      acc_nxt = VMAX;
      sat_now = 1'b1;
    end else if (sum < VMIN_X) begin
      acc_nxt = VMIN;
      sat_now = 1'b1;
    end
  end

  // The closing cycle's own step is folded into the reported value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      sticky    <= 1'b0;
      velocity  <= '0;
      vel_sat   <= 1'b0;
      vel_valid <= 1'b0;
    end else begin
      vel_valid <= 1'b0;
      if (!en) begin
        acc    <= '0;
        sticky <= 1'b0;
      end else if (win_end) begin
        velocity  <= acc_nxt;
        vel_sat   <= sticky | sat_now;
        vel_valid <= 1'b1;
        acc       <= '0;
        sticky    <= 1'b0;
      end else begin
        acc    <= acc_nxt;
        sticky <= sticky | sat_now;
      end
    end
  end

  // ---- edge-to-edge period ----
  logic [PER_W-1:0] pcnt, pinc;
  logic             have_edge, last_dir;

  assign pinc = (pcnt == PMAX) ? PMAX : pcnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt         <= '0;
      have_edge    <= 1'b0;
      last_dir     <= DIR_DOWN;
      period       <= '0;
      period_dir   <= 1'b0;
      period_valid <= 1'b0;
      stalled      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (!en) begin
        pcnt      <= '0;
        have_edge <= 1'b0;
        stalled   <= 1'b0;
      end else if (evt.vld) begin
        // A reversal only re-arms; only same-direction pairs give a period
        if (have_edge && evt.dir == last_dir) begin
          period       <= pinc;
          period_dir   <= evt.dir;
          period_valid <= 1'b1;
        end
        pcnt      <= '0;
        have_edge <= 1'b1;
        last_dir  <= evt.dir;
        stalled   <= 1'b0;
      end else begin
        pcnt <= pinc;
        if (pinc == PMAX) begin
          stalled   <= 1'b1;
          have_edge <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_quadrature_velocity_estimator.sv
// Directed scoreboard bench: expected window/period results are queued with the
// stimulus and popped whenever the DUT strobes a valid.
module tb_quadrature_velocity_estimator;

  logic clk = 1'b0, rst = 1'b1, en = 1'b0, up = 1'b0, down = 1'b0;
  always #5 clk = ~clk;

  logic signed [15:0] velocity;
  logic               vel_valid, vel_sat, period_dir, period_valid, stalled;
  logic [7:0]         period;
  logic signed [3:0]  velocity_b;
  logic               vel_valid_b, vel_sat_b, period_dir_b, period_valid_b, stalled_b;
  logic [7:0]         period_b;

  quadrature_velocity_estimator #(.WINDOW_CYCLES(100), .VEL_W(16), .PER_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .down(down),
    .velocity(velocity), .vel_valid(vel_valid), .vel_sat(vel_sat),
    .period(period), .period_dir(period_dir), .period_valid(period_valid),
    .stalled(stalled)
  );

  quadrature_velocity_estimator #(.WINDOW_CYCLES(100), .VEL_W(4), .PER_W(8)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .down(down),
    .velocity(velocity_b), .vel_valid(vel_valid_b), .vel_sat(vel_sat_b),
    .period(period_b), .period_dir(period_dir_b), .period_valid(period_valid_b),
    .stalled(stalled_b)
  );

  typedef struct { logic signed [15:0] vel; logic sat; } vexp_t;
  typedef struct { logic [7:0] per; logic dir; } pexp_t;

  vexp_t vq[$], bq[$];
  pexp_t pq[$];
  vexp_t ve, vb;
  pexp_t pe;
  int    n_tests = 0, n_fail = 0;
  logic  chk_b = 1'b0;
  logic  early;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic exp_vel(input int v, input logic s, input bit to_b);
    vexp_t t;
    t.vel = 16'(v);
    t.sat = s;
    if (to_b) bq.push_back(t);
    else      vq.push_back(t);
  endtask

  task automatic exp_per(input int p, input logic d, input int n);
    pexp_t t;
    t.per = 8'(p);
    t.dir = d;
    for (int k = 0; k < n; k++) pq.push_back(t);
  endtask

  task automatic tick(input logic e, input logic u, input logic d);
    @(negedge clk);
    en = e; up = u; down = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_velocity"}, velocity, 0);
    chk({tag, "_vel_valid"}, vel_valid, 0);
    chk({tag, "_vel_sat"}, vel_sat, 0);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_period_dir"}, period_dir, 0);
    chk({tag, "_period_valid"}, period_valid, 0);
    chk({tag, "_stalled"}, stalled, 0);
    chk({tag, "_b_outs"}, {velocity_b, vel_valid_b, vel_sat_b, period_b,
                           period_dir_b, period_valid_b, stalled_b}, 0);
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (vel_valid) begin
      chk("vel_expected_any", vq.size() != 0, 1);
      if (vq.size() != 0) begin
        ve = vq.pop_front();
        chk("velocity", velocity, ve.vel);
        chk("vel_sat", vel_sat, ve.sat);
      end
    end
    if (period_valid) begin
      chk("per_expected_any", pq.size() != 0, 1);
      if (pq.size() != 0) begin
        pe = pq.pop_front();
        chk("period", period, pe.per);
        chk("period_dir", period_dir, pe.dir);
      end
    end
    if (chk_b && vel_valid_b) begin
      chk("b_expected_any", bq.size() != 0, 1);
      if (bq.size() != 0) begin
        vb = bq.pop_front();
        chk("b_velocity", velocity_b, vb.vel);
        chk("b_vel_sat", vel_sat_b, vb.sat);
      end
    end
  end

  initial begin
    #2 rst = 1'b0;
    #1 chk_all_zero("rst_init");

    // Forward: up every 10 cycles, 3.5 windows
    for (int i = 0; i < 3; i++) exp_vel(10, 1'b0, 1'b0);
    exp_per(10, 1'b1, 34);
    for (int i = 0; i < 350; i++) begin
      tick(1'b1, (i % 10) == 0, 1'b0);
      if (i == 0) rst = 1'b1;
    end

    // Reset mid-window clears everything immediately
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk_all_zero("rst_mid");

    // First window after release closes exactly WINDOW_CYCLES cycles later
    exp_vel(0, 1'b0, 1'b0);
    early = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      if (i == 0) rst = 1'b1;
      if (vel_valid) early = 1'b1;
    end
    chk("vel_early", early, 0);
    tick(1'b1, 1'b0, 1'b0);
    chk("vel_latency", vel_valid, 1);

    // Reverse every 4 cycles, with one up&down collision in the third window
    tick(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) exp_vel(-25, 1'b0, 1'b0);
    exp_per(4, 1'b0, 74);
    for (int i = 0; i < 300; i++)
      tick(1'b1, i == 202, ((i % 4) == 0) || (i == 202));

    // Saturation on the narrow instance, then an idle window
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk_b = 1'b1;
    exp_vel(100, 1'b0, 1'b0); exp_vel(0, 1'b0, 1'b0);
    exp_vel(7, 1'b1, 1'b1);   exp_vel(0, 1'b0, 1'b1);
    exp_per(1, 1'b1, 99);
    for (int i = 0; i < 200; i++) tick(1'b1, i < 100, 1'b0);

    // Edge on the final window cycle belongs to the closing window
    tick(1'b0, 1'b0, 1'b0);
    exp_vel(1, 1'b0, 1'b0); exp_vel(0, 1'b0, 1'b0);
    exp_vel(1, 1'b0, 1'b1); exp_vel(0, 1'b0, 1'b1);
    for (int i = 0; i < 200; i++) tick(1'b1, i == 99, 1'b0);

    // Stall, post-stall edge, reversal, then a same-direction period
    tick(1'b0, 1'b0, 1'b0);
    exp_vel(1, 1'b0, 1'b0); exp_vel(0, 1'b0, 1'b0);
    exp_vel(0, 1'b0, 1'b0); exp_vel(-1, 1'b0, 1'b0);
    exp_vel(1, 1'b0, 1'b1); exp_vel(0, 1'b0, 1'b1);
    exp_vel(0, 1'b0, 1'b1); exp_vel(-1, 1'b0, 1'b1);
    exp_per(30, 1'b0, 1);
    for (int i = 0; i < 400; i++) begin
      tick(1'b1, (i == 0) || (i == 300), (i == 320) || (i == 350));
      if (i == 250) chk("stalled_before", stalled, 0);
      if (i == 260) chk("stalled_set", stalled, 1);
      if (i == 310) chk("stalled_clear", stalled, 0);
    end

    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
    chk("vel_queue_drained", vq.size(), 0);
    chk("b_queue_drained", bq.size(), 0);
    chk("per_queue_drained", pq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/quadrature_velocity_estimator.md
Name: quadrature_velocity_estimator

Overview:
- Sits directly downstream of the quadrature decoder and consumes its single-cycle `up`/`down` edge strobes.
- Produces two speed estimates for the control loop:
  - a signed edge count per fixed sample window (M-method, high speed);
  - an edge-to-edge period in clock cycles (T-method, low speed), with stall detection.

Parameters:
- WINDOW_CYCLES, 1000: sample window length in clk cycles (>= 2).
- VEL_W, 16: width of signed windowed velocity output.
- PER_W, 24: width of unsigned period counter/output.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- en  input  1  measurement enable; low clears window/period state.
- up  input  1  one-cycle strobe: one forward edge from the decoder.
- down  input  1  one-cycle strobe: one reverse edge from the decoder.
- velocity  output  VEL_W  signed net edges in the last completed window.
- vel_valid  output  1  one-cycle strobe, `velocity` updated.
- vel_sat  output  1  last completed window saturated.
- period  output  PER_W  cycles between the last two same-direction edges.
- period_dir  output  1  direction of the last period (1 = up).
- period_valid  output  1  one-cycle strobe, `period` updated.
- stalled  output  1  no edge for 2^PER_W-1 cycles.

Behaviour:
- Reset (rst=0, async): all outputs 0; window counter, accumulator, period counter and `have_edge` cleared.
- Net step per cycle:
  - up&!down = +1; down&!up = -1.
  - up&down simultaneously = 0, treated as no edge for both the window and period paths.
- Window timer:
  - Counts 0..WINDOW_CYCLES-1 while en=1, then wraps to 0.
  - While en=0: held at 0, accumulator cleared, no vel_valid. `velocity`/`vel_sat` keep their last values.
- Accumulator:
  - Signed VEL_W; adds the net step each cycle.
  - Saturates at +2^(VEL_W-1)-1 and -2^(VEL_W-1); sets a sticky window-sat bit.
- Window close (timer == WINDOW_CYCLES-1):
  - The net step of that same cycle is included.
  - On the next clk edge: velocity <= acc+step (saturated), vel_sat <= sticky bit, vel_valid = 1 for exactly one cycle.
  - Accumulator and sticky bit restart at 0; the first window cycle accumulates normally.
  - First vel_valid arrives WINDOW_CYCLES cycles after en rises.
- Period counter:
  - Unsigned PER_W; increments each cycle while en=1; saturates at all-ones.
  - When it reaches all-ones: stalled=1, have_edge=0.
- Edge event (net step != 0) with en=1:
  - If have_edge=1 and the direction equals the previous edge direction: period <= counter+1 (saturated), period_dir <= direction, period_valid=1 for one cycle.
  - A direction reversal updates no period; it only re-arms the measurement.
  - Every edge: counter restarts at 0, have_edge=1, last direction stored, stalled=0.
- en=0: period counter=0, have_edge=0, stalled=0; period/period_dir hold.
- Latency: all outputs are registered, updated one cycle after the causing input sample.
- rst mid-window: immediate clear. After release, the window restarts at 0 on the first cycle with en=1.

Decomposition:
- Package qenc_pkg:
  - default widths (VEL_W, PER_W);
  - direction constants DIR_UP=1, DIR_DOWN=0;
  - signed saturation limit localparams helper.
- Sub-module qenc_window_timer: parameterised WINDOW_CYCLES counter with en and a one-cycle `win_end` output. Reused by later speed and position-sampling blocks.

Test Plan:
- Reset: drive rst=0 mid-operation -> all outputs 0 immediately. After release with en=1, the first vel_valid comes exactly WINDOW_CYCLES cycles later.
- Constant forward speed (WINDOW_CYCLES=100, VEL_W=16, up strobe every 10 cycles starting cycle 0):
  - -> each window reports velocity=+10, vel_sat=0, vel_valid one cycle wide every 100 cycles;
  - -> period=10, period_dir=1 from the 2nd edge on.
- Reverse and simultaneous:
  - down strobe every 4 cycles -> velocity=-25 per window.
  - Adding an up&down same-cycle pulse changes neither velocity nor period, and does not restart the period counter.
- Saturation (VEL_W=4, up every cycle, WINDOW_CYCLES=100) -> velocity=+7, vel_sat=1. The next window with no edges -> velocity=0, vel_sat=0.
- Window boundary: single up strobe on the final window cycle (timer=99) -> counted in the closing window, velocity=+1; the next window reports 0.
- Stall and reversal (PER_W=8):
  - no edges for 255 cycles after an edge -> stalled=1, and the next edge produces no period_valid;
  - up, then down 20 cycles later -> no period_valid; a second down 30 cycles later -> period=30, period_dir=0.
